// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Moore state register plus a state-decoded control word.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic [3:0] state,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pcen
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  state_t cur, nxt;
  logic   pcwrite;
  logic   branch;

  always_ff @(posedge clk) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  assign state = cur;

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:   nxt = DECODE;
      DECODE: begin
        unique case (1'b1)
          (op == OP_LW) || (op == OP_SW): nxt = MEMADR;
          op == OP_R:                     nxt = RTYPEEX;
          op == OP_BEQ:                   nxt = BEQEX;
          op == OP_ADDI:                  nxt = ADDIEX;
          op == OP_J:                     nxt = JEX;
          default:                        nxt = FETCH;
        endcase
      end
      // op is re-checked so a corrupted opcode cannot reach memory
      MEMADR: begin
        unique case (1'b1)
          op == OP_LW: nxt = MEMRD;
          op == OP_SW: nxt = MEMWR;
          default:     nxt = FETCH;
        endcase
      end
      MEMRD:   nxt = MEMWB;
      RTYPEEX: nxt = RTYPEWB;
      ADDIEX:  nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    pcsrc    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    case (cur)
      FETCH: begin
        irwrite = 1'b1;
        alusrcb = 2'b01;
        pcwrite = 1'b1;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: regwrite = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen = pcwrite | (branch & zero);

endmodule
